// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// Owner encoding doubles as the datapath 2:1 select value.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter: counts DM wins while IF is waiting.
// Clear has priority over increment; the count sticks at Limit.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(Limit);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LimitCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LimitCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and mem-stage (DM) requesters onto one memory port,
// one access outstanding at a time; DM has priority unless IF has been starved.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              src_sel
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              src_sel_q, src_sel_d;
  logic              grant_if, grant_dm;
  logic              starve_inc, starve_clr, starve_at_limit;

  arb_starve_cnt #(
    .Limit(STARVE_MAX)
  ) u_starve_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (starve_inc),
    .clr_i     (starve_clr),
    .at_limit_o(starve_at_limit)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    src_sel_d  = src_sel_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    dm_rvalid  = 1'b0;
    dm_rdata   = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        // Grants are gated by rst_n so nothing is accepted while reset is held.
        grant_if   = rst_n && if_req && (!dm_req || starve_at_limit);
        grant_dm   = rst_n && dm_req && !grant_if;
        starve_clr = grant_if || !if_req;
        starve_inc = grant_dm && if_req;
        if (grant_if) begin
          addr_d    = if_addr;
          we_d      = 1'b0;
          wdata_d   = '0;
          src_sel_d = SRC_IF;
          state_d   = BUSY_IF;
        end else if (grant_dm) begin
          addr_d    = dm_addr;
          we_d      = dm_we;
          wdata_d   = dm_wdata;
          src_sel_d = SRC_DM;
          state_d   = BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ready) begin
          state_d = IDLE;
          if (state_q == BUSY_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else begin
            dm_rvalid = 1'b1;
            dm_rdata  = we_q ? '0 : mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      src_sel_q <= SRC_IF;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      src_sel_q <= src_sel_d;
    end
  end

  assign if_gnt  = grant_if;
  assign dm_gnt  = grant_dm;
  assign src_sel = src_sel_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive DM grants while IF waits before IF is forced (1..15).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch-stage read request; if_addr in 32 held stable while if_req high.
REQ-005 if_gnt  out  1  request accepted this cycle; if_rvalid out 1 read data valid pulse; if_rdata out 32.
REQ-006 dm_req  in  1  mem-stage request; dm_we in 1 write; dm_addr in 32; dm_wdata in 32.
REQ-007 dm_gnt  out  1  accepted; dm_rvalid out 1 read data or write-ack pulse; dm_rdata out 32.
REQ-008 mem_en  out  1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_rdata in 32; mem_ready in 1 (access completes in cycle it is high).
REQ-009 src_sel  out  1  current owner, 0=IF, 1=DM; drives the shared datapath 2:1 select lines.

Function
REQ-010 FSM states: IDLE, BUSY_IF, BUSY_DM; single shared port, one access outstanding.
REQ-011 In IDLE, if_gnt/dm_gnt are combinational from the arbitration decision; requester may drop req the cycle after gnt.
REQ-012 Arbitration: DM wins when both request, unless starve count == STARVE_MAX, then IF wins.
REQ-013 On grant: latch addr, we (0 for IF), wdata; set src_sel; next state BUSY_IF/BUSY_DM.
REQ-014 In BUSY_x: mem_en=1, mem_addr/mem_we/mem_wdata from latched registers; no gnt asserted.
REQ-015 In BUSY_x with mem_ready=1: x_rvalid=1 same cycle, x_rdata=mem_rdata (reads); for DM write dm_rvalid=1, dm_rdata=0; next state IDLE.
REQ-016 Minimum access = 2 cycles (grant cycle + one BUSY cycle); no back-to-back grant in completion cycle.
REQ-017 mem_ready while IDLE is ignored; never generates rvalid.
REQ-018 Starve counter (4 bits): +1 on DM grant while if_req=1; cleared on IF grant or when if_req=0 in IDLE; saturates at STARVE_MAX.
REQ-019 Outside their own completion cycle, if_rvalid/dm_rvalid=0 and rdata outputs hold 0.
REQ-020 src_sel holds last owner in IDLE; mem_we=0 whenever mem_en=0.
REQ-021 No timeout: BUSY waits indefinitely for mem_ready.

Reset
REQ-022 rst_n low asynchronously forces IDLE, starve count 0, latched regs 0, src_sel 0, all outputs 0.
REQ-023 Reset mid-BUSY abandons the access: mem_en drops immediately, no rvalid issued, requester must re-request.
REQ-024 First grant possible in first cycle after rst_n deasserts.

Structure
REQ-025 Shared package mem_arb_pkg: state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_DM=2'd2), SRC_IF=1'b0, SRC_DM=1'b1, ADDR_W=32, DATA_W=32.
REQ-026 One sub-module: arb_starve_cnt (saturating counter, inc/clr/limit inputs, at_limit output).
REQ-027 Single always block for state/registers, separate combinational block for grant and outputs.

Verification
REQ-028 rst_n=0 for 3 cycles with both reqs high -> all outputs 0, no gnt, mem_en=0.
REQ-029 IF read 0x100, mem_ready 2 cycles after grant, mem_rdata 0xDEADBEEF -> if_gnt cycle 0, mem_en cycles 1-2, if_rvalid + if_rdata=0xDEADBEEF cycle 2, src_sel=0.
REQ-030 if_req and dm_req (read 0x40) same cycle -> dm_gnt first, src_sel=1; IF granted in next IDLE cycle.
REQ-031 Both reqs held continuously, STARVE_MAX=4, mem_ready=1 always -> grant order DM,DM,DM,DM,IF,DM...
REQ-032 DM write 0x200/0x12345678 -> mem_we=1, mem_wdata=0x12345678 during BUSY_DM; dm_rvalid pulse, if_rvalid never.
REQ-033 rst_n pulsed low during BUSY_DM before mem_ready -> mem_en=0 same cycle, no dm_rvalid, IDLE after release.
